// File: rtl/cache_set_store.sv
// ---------------------------------------------------------------------------
// cache_set_store
// Storage core of a 4-way set-associative cache. It holds per-way valid,
// dirty, tag and data arrays plus a 3-bit tree pseudo-LRU state per set.
// A whole set is captured into output registers one cycle after a read.
// Hit detection, way selection and the next PLRU state are combinational
// functions of those registers and the lookup tag.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_read        capture set i_rindex into the output registers
//   i_rindex      set index to read
//   i_windex      set index to write / LRU-update
//   i_lookup_tag  tag compared against the registered set
//   i_load        fill/write the selected way at i_windex
//   i_tag_in      tag stored on load
//   i_dirty_in    dirty bit stored on load
//   i_byte_en     per-byte write enable for i_line_in
//   i_line_in     write data
//   i_lru_update  write the new PLRU state for i_windex
//   o_hits        per-way valid & tag match
//   o_hit         any way hits
//   o_way         one-hot selected way (lowest hit, else PLRU victim)
//   o_sel_valid   valid bit of the selected way
//   o_sel_dirty   dirty bit of the selected way
//   o_sel_tag     tag of the selected way (write-back address)
//   o_sel_line    line of the selected way
// ---------------------------------------------------------------------------
module cache_set_store #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
  parameter int S_MASK   = 2**S_OFFSET,
  parameter int S_LINE   = 8*S_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [S_INDEX-1:0] i_rindex,
  input  logic [S_INDEX-1:0] i_windex,
  input  logic [S_TAG-1:0]  i_lookup_tag,
  input  logic              i_load,
  input  logic [S_TAG-1:0]  i_tag_in,
  input  logic              i_dirty_in,
  input  logic [S_MASK-1:0] i_byte_en,
  input  logic [S_LINE-1:0] i_line_in,
  input  logic              i_lru_update,
  output logic [3:0]        o_hits,
  output logic              o_hit,
  output logic [3:0]        o_way,
  output logic              o_sel_valid,
  output logic              o_sel_dirty,
  output logic [S_TAG-1:0]  o_sel_tag,
  output logic [S_LINE-1:0] o_sel_line
);

  // The PLRU tree below is a 3-bit tree, so the way count is fixed at four.
  localparam int S_WAY    = 2;
  localparam int NUM_WAYS = 2**S_WAY;
  localparam int NUM_SETS = 2**S_INDEX;

  // Storage arrays
  logic [NUM_SETS-1:0] r_valid_mem [NUM_WAYS];
  logic [NUM_SETS-1:0] r_dirty_mem [NUM_WAYS];
  logic [S_TAG-1:0]    r_tag_mem   [NUM_WAYS][NUM_SETS];
  logic [S_LINE-1:0]   r_data_mem  [NUM_WAYS][NUM_SETS];
  logic [2:0]          r_plru_mem  [NUM_SETS];

  // Registered view of the set last read
  logic [NUM_WAYS-1:0] r_valid_q;
  logic [NUM_WAYS-1:0] r_dirty_q;
  logic [S_TAG-1:0]    r_tag_q  [NUM_WAYS];
  logic [S_LINE-1:0]   r_line_q [NUM_WAYS];
  logic [2:0]          r_plru_q;

  logic [NUM_WAYS-1:0] w_hits;
  logic                w_hit;
  logic [NUM_WAYS-1:0] w_lowest_hit;
  logic [NUM_WAYS-1:0] w_victim;
  logic [NUM_WAYS-1:0] w_way;
  logic [S_WAY-1:0]    w_way_idx;
  logic [2:0]          w_plru_next;
  logic                w_same_index;
  logic [S_LINE-1:0]   w_merged [NUM_WAYS];

  // Hit detection per way
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
      assign w_hits[gi] = r_valid_q[gi] & (r_tag_q[gi] == i_lookup_tag);
    end
  endgenerate

  assign w_hit = |w_hits;
  // x & -x isolates the lowest set bit: lowest-index hit wins.
  assign w_lowest_hit = w_hits & (~w_hits + 4'd1);

  // Tree PLRU victim: b0 picks the half, b1/b2 pick the way within it.
  always_comb begin
    w_victim = 4'b0000;
    if (!r_plru_q[0]) begin
      w_victim = r_plru_q[1] ? 4'b0010 : 4'b0001;
    end else begin
      w_victim = r_plru_q[2] ? 4'b1000 : 4'b0100;
    end
  end

  assign w_way = w_hit ? w_lowest_hit : w_victim;
  assign w_way_idx = {w_way[3] | w_way[2], w_way[3] | w_way[1]};

  // Point the tree away from the accessed way; the untouched half keeps its bit.
  always_comb begin
    w_plru_next = r_plru_q;
    if (!w_way_idx[1]) begin
      w_plru_next[0] = 1'b1;
      w_plru_next[1] = ~w_way_idx[0];
    end else begin
      w_plru_next[0] = 1'b0;
      w_plru_next[2] = ~w_way_idx[0];
    end
  end

  assign w_same_index = (i_windex == i_rindex);

  // Byte-merged line as it will look after the write; used for forwarding.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_merged[w] = r_data_mem[w][i_windex];
      for (int b = 0; b < S_MASK; b++) begin
        if (i_byte_en[b]) begin
          w_merged[w][8*b +: 8] = i_line_in[8*b +: 8];
        end
      end
    end
  end

  // Valid / dirty / PLRU arrays are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_valid_mem[w] <= '0;
        r_dirty_mem[w] <= '0;
      end
      for (int s = 0; s < NUM_SETS; s++) begin
        r_plru_mem[s] <= 3'b000;
      end
    end else begin
      if (i_load) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (w_way[w]) begin
            r_valid_mem[w][i_windex] <= 1'b1;
            r_dirty_mem[w][i_windex] <= i_dirty_in;
          end
        end
      end
      if (i_lru_update) begin
        r_plru_mem[i_windex] <= w_plru_next;
      end
    end
  end

  // Tag and data arrays hold their contents through reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (w_way[w]) begin
          r_tag_mem[w][i_windex] <= i_tag_in;
          for (int b = 0; b < S_MASK; b++) begin
            if (i_byte_en[b]) begin
              r_data_mem[w][i_windex][8*b +: 8] <= i_line_in[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Output registers; a write to the set being read is forwarded so the
  // registered view always shows post-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= '0;
      r_dirty_q <= '0;
      r_plru_q  <= 3'b000;
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_tag_q[w]  <= '0;
        r_line_q[w] <= '0;
      end
    end else if (i_read) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (i_load && w_way[w] && w_same_index) begin
          r_valid_q[w] <= 1'b1;
          r_dirty_q[w] <= i_dirty_in;
          r_tag_q[w]   <= i_tag_in;
          r_line_q[w]  <= w_merged[w];
        end else begin
          r_valid_q[w] <= r_valid_mem[w][i_rindex];
          r_dirty_q[w] <= r_dirty_mem[w][i_rindex];
          r_tag_q[w]   <= r_tag_mem[w][i_rindex];
          r_line_q[w]  <= r_data_mem[w][i_rindex];
        end
      end
      if (i_lru_update && w_same_index) begin
        r_plru_q <= w_plru_next;
      end else begin
        r_plru_q <= r_plru_mem[i_rindex];
      end
    end
  end

  assign o_hits      = w_hits;
  assign o_hit       = w_hit;
  assign o_way       = w_way;
  assign o_sel_valid = r_valid_q[w_way_idx];
  assign o_sel_dirty = r_dirty_q[w_way_idx];
  assign o_sel_tag   = r_tag_q[w_way_idx];
  assign o_sel_line  = r_line_q[w_way_idx];

endmodule

// File: tb/tb_cache_set_store.sv
// ---------------------------------------------------------------------------
// tb_cache_set_store
// Directed scenarios followed by random traffic, checked against a
// behavioural model of the set store (plain arrays of ways x sets).
// ---------------------------------------------------------------------------
module tb_cache_set_store;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          read;
  logic [2:0]    rindex;
  logic [2:0]    windex;
  logic [23:0]   lookup_tag;
  logic          load;
  logic [23:0]   tag_in;
  logic          dirty_in;
  logic [31:0]   byte_en;
  logic [255:0]  line_in;
  logic          lru_update;
  logic [3:0]    hits;
  logic          hit;
  logic [3:0]    way;
  logic          sel_valid;
  logic          sel_dirty;
  logic [23:0]   sel_tag;
  logic [255:0]  sel_line;

  int n_assert = 0;
  int n_fail   = 0;

  cache_set_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (read),
    .i_rindex     (rindex),
    .i_windex     (windex),
    .i_lookup_tag (lookup_tag),
    .i_load       (load),
    .i_tag_in     (tag_in),
    .i_dirty_in   (dirty_in),
    .i_byte_en    (byte_en),
    .i_line_in    (line_in),
    .i_lru_update (lru_update),
    .o_hits       (hits),
    .o_hit        (hit),
    .o_way        (way),
    .o_sel_valid  (sel_valid),
    .o_sel_dirty  (sel_dirty),
    .o_sel_tag    (sel_tag),
    .o_sel_line   (sel_line)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic         m_valid  [4][8];
  logic         m_dirty  [4][8];
  logic [23:0]  m_tag    [4][8];
  logic         m_tknown [4][8];
  logic [255:0] m_data   [4][8];
  logic [31:0]  m_known  [4][8];
  logic [2:0]   m_plru   [8];

  logic         q_valid  [4];
  logic         q_dirty  [4];
  logic [23:0]  q_tag    [4];
  logic         q_tknown [4];
  logic [255:0] q_line   [4];
  logic [31:0]  q_known  [4];
  logic [2:0]   q_plru;

  function automatic int m_way_idx(input logic [23:0] lt);
    for (int i = 0; i < 4; i++)
      if (q_valid[i] && q_tag[i] == lt) return i;
    if (q_plru[0] == 1'b0) return int'(q_plru[1]);
    return 2 + int'(q_plru[2]);
  endfunction

  function automatic logic [255:0] expand(input logic [31:0] m);
    logic [255:0] e;
    for (int b = 0; b < 32; b++) e[8*b +: 8] = {8{m[b]}};
    return e;
  endfunction

  task automatic m_reset();
    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s < 8; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
      q_valid[w] = 1'b0;  q_dirty[w] = 1'b0;
      q_tag[w] = '0;      q_tknown[w] = 1'b1;
      q_line[w] = '0;     q_known[w] = '1;
    end
    for (int s = 0; s < 8; s++) m_plru[s] = 3'b000;
    q_plru = 3'b000;
  endtask

  task automatic chk(input string tg, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic check_model(input string tg);
    int wi;
    logic [3:0] eh;
    logic [255:0] mk;
    wi = m_way_idx(lookup_tag);
    for (int i = 0; i < 4; i++) eh[i] = q_valid[i] && (q_tag[i] == lookup_tag);
    chk({tg, ".hits"}, 256'(hits), 256'(eh));
    chk({tg, ".hit"}, 256'(hit), 256'(|eh));
    chk({tg, ".way"}, 256'(way), 256'(4'b0001 << wi));
    chk({tg, ".sel_valid"}, 256'(sel_valid), 256'(q_valid[wi]));
    chk({tg, ".sel_dirty"}, 256'(sel_dirty), 256'(q_dirty[wi]));
    if (q_tknown[wi]) chk({tg, ".sel_tag"}, 256'(sel_tag), 256'(q_tag[wi]));
    mk = expand(q_known[wi]);
    if (q_known[wi] != 32'd0) chk({tg, ".sel_line"}, sel_line & mk, q_line[wi] & mk);
  endtask

  // One clock: the model applies the same edge, then outputs are compared.
  task automatic tick(input string tg);
    int w;
    logic [2:0] np;
    w  = m_way_idx(lookup_tag);
    np = q_plru;
    if (w < 2) begin
      np[0] = 1'b1; np[1] = (w % 2 == 0);
    end else begin
      np[0] = 1'b0; np[2] = (w % 2 == 0);
    end
    @(posedge clk);
    if (load) begin
      m_valid[w][windex]  = 1'b1;
      m_dirty[w][windex]  = dirty_in;
      m_tag[w][windex]    = tag_in;
      m_tknown[w][windex] = 1'b1;
      for (int b = 0; b < 32; b++)
        if (byte_en[b]) m_data[w][windex][8*b +: 8] = line_in[8*b +: 8];
      m_known[w][windex] = m_known[w][windex] | byte_en;
    end
    if (lru_update) m_plru[windex] = np;
    if (read) begin
      for (int i = 0; i < 4; i++) begin
        q_valid[i]  = m_valid[i][rindex];
        q_dirty[i]  = m_dirty[i][rindex];
        q_tag[i]    = m_tag[i][rindex];
        q_tknown[i] = m_tknown[i][rindex];
        q_line[i]   = m_data[i][rindex];
        q_known[i]  = m_known[i][rindex];
      end
      q_plru = m_plru[rindex];
    end
    #1;
    check_model(tg);
  endtask

  task automatic idle();
    read = 1'b0; rindex = '0; windex = '0; lookup_tag = 24'hFFFFFF;
    load = 1'b0; tag_in = '0; dirty_in = 1'b0; byte_en = '0;
    line_in = '0; lru_update = 1'b0;
  endtask

  // Reset asserted between edges; outputs are checked while reset is held.
  task automatic apply_reset(input string tg);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk({tg, ".hit"}, 256'(hit), 256'(1'b0));
    chk({tg, ".hits"}, 256'(hits), 256'(4'b0000));
    chk({tg, ".way"}, 256'(way), 256'(4'b0001));
    chk({tg, ".sel_valid"}, 256'(sel_valid), 256'(1'b0));
    chk({tg, ".sel_dirty"}, 256'(sel_dirty), 256'(1'b0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model({tg, ".after"});
  endtask

  localparam logic [23:0] POOL [5] = '{24'h100000, 24'h100001, 24'h100002,
                                       24'h100003, 24'hC00301};
  logic [255:0] a5_line;
  logic [255:0] ff_line;

  initial begin
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++) begin
        m_tknown[w][s] = 1'b0;
        m_known[w][s]  = '0;
        m_tag[w][s]    = '0;
        m_data[w][s]   = '0;
      end
    m_reset();
    idle();
    a5_line = {32{8'hA5}};
    ff_line = {32{8'hFF}};

    apply_reset("reset0");

    // Prefill every way of every set; four PLRU-driven misses visit all ways.
    for (int s = 0; s < 8; s++) begin
      idle(); read = 1'b1; rindex = 3'(s);
      tick("prefill.rd");
      for (int k = 0; k < 4; k++) begin
        read = 1'b1; rindex = 3'(s); windex = 3'(s);
        load = 1'b1; lru_update = 1'b1; byte_en = '1;
        tag_in = {8'hC0, 8'(s), 8'(k)}; dirty_in = k[0];
        line_in = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
        tick("prefill.wr");
      end
    end

    // Reset in the middle of activity
    idle(); read = 1'b1; rindex = 3'd3; lookup_tag = 24'hC00301;
    tick("pre_reset");
    apply_reset("reset_mid");

    // PLRU walk on set 0
    idle(); read = 1'b1; rindex = 3'd0;
    tick("plru.rd");
    chk("plru.init_way", 256'(way), 256'(4'b0001));
    read = 1'b1; windex = 3'd0; lru_update = 1'b1;
    tick("plru.upd0");
    chk("plru.victim_after_way0", 256'(way), 256'(4'b0100));
    tick("plru.upd2");
    chk("plru.victim_after_way2", 256'(way), 256'(4'b0010));

    // Fill set 2 then look it up
    idle(); read = 1'b1; rindex = 3'd2;
    tick("fill.rd");
    load = 1'b1; windex = 3'd2; tag_in = 24'h123456; dirty_in = 1'b1;
    byte_en = '1; line_in = a5_line;
    tick("fill.wr");
    idle(); read = 1'b1; rindex = 3'd2; lookup_tag = 24'h123456;
    tick("fill.lookup");
    chk("fill.hits", 256'(hits), 256'(4'b0001));
    chk("fill.hit", 256'(hit), 256'(1'b1));
    chk("fill.sel_dirty", 256'(sel_dirty), 256'(1'b1));
    chk("fill.sel_line", sel_line, a5_line);

    // Same-edge read and write to set 5
    idle(); read = 1'b1; rindex = 3'd5; lookup_tag = 24'h0ABCDE;
    tick("fwd.rd");
    load = 1'b1; windex = 3'd5; tag_in = 24'h0ABCDE; byte_en = '1;
    line_in = {8{32'h5EED_0001}};
    tick("fwd.wr");
    chk("fwd.sel_tag", 256'(sel_tag), 256'(24'h0ABCDE));
    chk("fwd.sel_line", sel_line, {8{32'h5EED_0001}});

    // Byte mask on set 6
    idle(); read = 1'b1; rindex = 3'd6; lookup_tag = 24'h000777;
    tick("mask.rd");
    load = 1'b1; windex = 3'd6; tag_in = 24'h000777; byte_en = '1; line_in = '0;
    tick("mask.zero");
    byte_en = 32'h0000_0001; line_in = ff_line;
    tick("mask.byte0");
    idle(); read = 1'b1; rindex = 3'd6; lookup_tag = 24'h000777;
    tick("mask.readback");
    chk("mask.sel_line", sel_line, 256'hFF);

    // Miss on set 2: victim is way0 holding 24'h123456
    idle(); read = 1'b1; rindex = 3'd2; lookup_tag = 24'hFFFFFF;
    tick("miss.rd");
    chk("miss.hit", 256'(hit), 256'(1'b0));
    chk("miss.way", 256'(way), 256'(4'b0001));
    chk("miss.sel_tag", 256'(sel_tag), 256'(24'h123456));

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      read       = ($urandom % 4) != 0;
      rindex     = 3'($urandom);
      windex     = ($urandom % 2 == 0) ? rindex : 3'($urandom);
      lookup_tag = POOL[$urandom % 5];
      load       = ($urandom % 3) == 0;
      tag_in     = POOL[$urandom % 4];
      dirty_in   = 1'($urandom);
      byte_en    = $urandom;
      line_in    = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
      lru_update = 1'($urandom);
      tick("rand");
      if (n == 700) begin
        idle();
        apply_reset("reset_rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
